mul_div_unit: RTL and testbench

Iterative multiply/divide unit for the Term_PC datapath, sitting directly downstream of the register file. It consumes the two read ports (rs on A, rt on B) and executes MULT/MULTU/DIV/DIVU over SIZE+1 cycles, holding results in private HI/LO registers. It also supports MTHI/MTLO writes, and flags divide-by-zero. The control unit stalls on Busy and reads HI/LO for MFHI/MFLO.

---
 rtl/mul_div_unit.sv | 160 ++++++++++++++++
 tb/tb_mul_div_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one bit
// per cycle over SIZE cycles, followed by a sign-fix cycle that writes HI/LO.
module mul_div_unit #(
    parameter int SIZE = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [SIZE-1:0] a_i,
    input  logic [SIZE-1:0] b_i,
    input  logic            mthi_i,
    input  logic            mtlo_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            div_zero_o,
    output logic [SIZE-1:0] hi_o,
    output logic [SIZE-1:0] lo_o
);

    localparam int CW = $clog2(SIZE);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        FINISH
    } state_t;

    state_t state_q, state_d;

    logic [2*SIZE-1:0] acc_q;
    logic [SIZE-1:0]   mcand_q;
    logic [CW-1:0]     cnt_q;
    logic              div_q;
    logic              sign_q;
    logic              rem_sign_q;
    logic [SIZE-1:0]   hi_q;
    logic [SIZE-1:0]   lo_q;
    logic              done_q;
    logic              div_zero_q;

    // Operand decode for the Start cycle
    logic              op_signed;
    logic              op_div;
    logic              a_neg;
    logic              b_neg;
    logic [SIZE-1:0]   a_mag;
    logic [SIZE-1:0]   b_mag;
    logic              div_by_zero;

    assign op_signed   = op_i[0];
    assign op_div      = op_i[1];
    assign a_neg       = op_signed & a_i[SIZE-1];
    assign b_neg       = op_signed & b_i[SIZE-1];
    assign a_mag       = a_neg ? -a_i : a_i;
    assign b_mag       = b_neg ? -b_i : b_i;
    assign div_by_zero = op_div && (b_i == '0);

    // Multiply step: acc holds {partial product, remaining multiplier bits}
    logic [SIZE:0]     mul_sum;
    logic [2*SIZE-1:0] mul_next;

    assign mul_sum  = {1'b0, acc_q[2*SIZE-1:SIZE]} + {1'b0, mcand_q};
    assign mul_next = acc_q[0] ? {mul_sum, acc_q[SIZE-1:1]}
                               : {1'b0, acc_q[2*SIZE-1:1]};

    // Divide step: acc holds {remainder, dividend bits shifting into quotient}
    logic [SIZE:0]     div_partial;
    logic [SIZE:0]     div_diff;
    logic              div_ok;
    logic [SIZE-1:0]   div_rem;
    logic [2*SIZE-1:0] div_next;

    assign div_partial = acc_q[2*SIZE-1:SIZE-1];
    assign div_diff    = div_partial - {1'b0, mcand_q};
    assign div_ok      = ~div_diff[SIZE];
    assign div_rem     = div_ok ? div_diff[SIZE-1:0] : div_partial[SIZE-1:0];
    assign div_next    = {div_rem, acc_q[SIZE-2:0], div_ok};

    // Sign-corrected results used in FIX
    logic [2*SIZE-1:0] prod_fix;
    logic [SIZE-1:0]   quot_fix;
    logic [SIZE-1:0]   rem_fix;

    assign prod_fix = sign_q     ? -acc_q               : acc_q;
    assign quot_fix = sign_q     ? -acc_q[SIZE-1:0]     : acc_q[SIZE-1:0];
    assign rem_fix  = rem_sign_q ? -acc_q[2*SIZE-1:SIZE] : acc_q[2*SIZE-1:SIZE];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = div_by_zero ? FINISH : CALC;
            CALC:    if (cnt_q == CW'(SIZE-1)) state_d = FIX;
            FIX:     state_d = IDLE;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            mcand_q    <= '0;
            cnt_q      <= '0;
            div_q      <= 1'b0;
            sign_q     <= 1'b0;
            rem_sign_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == FIX) || (state_q == FINISH);
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (div_by_zero) begin
                            div_zero_q <= 1'b1;
                        end else begin
                            div_zero_q <= 1'b0;
                            div_q      <= op_div;
                            acc_q      <= {{SIZE{1'b0}}, (op_div ? a_mag : b_mag)};
                            mcand_q    <= op_div ? b_mag : a_mag;
                            sign_q     <= a_neg ^ b_neg;
                            rem_sign_q <= a_neg;
                            cnt_q      <= '0;
                        end
                    end else begin
                        if (mthi_i) hi_q <= a_i;
                        if (mtlo_i) lo_q <= a_i;
                    end
                end
                CALC: begin
                    acc_q <= div_q ? div_next : mul_next;
                    cnt_q <= cnt_q + CW'(1);
                end
                FIX: begin
                    if (div_q) begin
                        hi_q <= rem_fix;
                        lo_q <= quot_fix;
                    end else begin
                        hi_q <= prod_fix[2*SIZE-1:SIZE];
                        lo_q <= prod_fix[SIZE-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o     = (state_q != IDLE);
    assign done_o     = done_q;
    assign div_zero_o = div_zero_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected HI/LO/Div_Zero pushed at Start from an
// arithmetic reference model, popped and compared by a monitor on every Done pulse.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        mthi_i = 1'b0;
    logic        mtlo_i = 1'b0;
    logic        busy_o, done_o, div_zero_o;
    logic [31:0] hi_o, lo_o;

    mul_div_unit #(.SIZE(32)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .op_i(op_i),
        .a_i(a_i), .b_i(b_i), .mthi_i(mthi_i), .mtlo_i(mtlo_i),
        .busy_o(busy_o), .done_o(done_o), .div_zero_o(div_zero_o),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        string       tag;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every Done pulse retires the oldest outstanding operation
    always @(negedge clk) begin
        exp_t e;
        if (rst_ni && done_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected: actual done=1 required no pending op");
            end else begin
                e = exp_q.pop_front();
                chk({e.tag, "_hi"}, 64'(hi_o), 64'(e.hi));
                chk({e.tag, "_lo"}, 64'(lo_o), 64'(e.lo));
                chk({e.tag, "_dz"}, 64'(div_zero_o), 64'(e.dz));
                $display("txn %s: hi=%08h lo=%08h dz=%b", e.tag, hi_o, lo_o, div_zero_o);
            end
        end
    end

    // Reference model in plain arithmetic; drives one Start cycle
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic with_mtlo, input string tag);
        exp_t        e;
        int          sa, sb;
        logic [63:0] p;
        sa    = a;
        sb    = b;
        e.tag = tag;
        e.dz  = 1'b0;
        case (op)
            2'b00: begin p = 64'(a) * 64'(b); hi_m = p[63:32]; lo_m = p[31:0]; end
            2'b01: begin p = longint'(sa) * longint'(sb); hi_m = p[63:32]; lo_m = p[31:0]; end
            2'b10: begin
                if (b == 0) e.dz = 1'b1;
                else begin lo_m = a / b; hi_m = a % b; end
            end
            default: begin
                if (b == 0) e.dz = 1'b1;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo_m = 32'h8000_0000; hi_m = 32'h0;
                end else begin
                    lo_m = sa / sb; hi_m = sa % sb;
                end
            end
        endcase
        e.hi = hi_m;
        e.lo = lo_m;
        exp_q.push_back(e);
        op_i = op; a_i = a; b_i = b; start_i = 1'b1; mtlo_i = with_mtlo;
        @(negedge clk);
        start_i = 1'b0; mtlo_i = 1'b0; a_i = $urandom; b_i = $urandom;
    endtask

    task automatic wait_done(input int exp_cycles, input string tag);
        int n;
        n = busy_o ? 1 : 0;
        for (int i = 0; i < 200 && busy_o; i++) begin
            @(negedge clk);
            if (busy_o) n++;
        end
        chk({tag, "_busy_cycles"}, 64'(n), 64'(exp_cycles));
        chk({tag, "_done_pulse"}, 64'(done_o), 64'(1));
        @(negedge clk);
        chk({tag, "_done_low"}, 64'(done_o), 64'(0));
    endtask

    task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
        issue(op, a, b, 1'b0, tag);
        wait_done((op[1] && b == 0) ? 1 : 33, tag);
    endtask

    task automatic mt(input logic h, input logic l, input logic [31:0] v, input string tag);
        mthi_i = h; mtlo_i = l; a_i = v;
        @(negedge clk);
        mthi_i = 1'b0; mtlo_i = 1'b0;
        if (h) hi_m = v;
        if (l) lo_m = v;
        chk({tag, "_hi"}, 64'(hi_o), 64'(hi_m));
        chk({tag, "_lo"}, 64'(lo_o), 64'(lo_m));
        $display("txn %s: hi=%08h lo=%08h", tag, hi_o, lo_o);
    endtask

    initial begin
        logic [31:0] hi_prev, lo_prev, ra, rb;
        logic [1:0]  rop;
        repeat (3) @(negedge clk);
        chk("reset_hi", 64'(hi_o), 64'(0));
        chk("reset_lo", 64'(lo_o), 64'(0));
        chk("reset_busy", 64'(busy_o), 64'(0));
        chk("reset_done", 64'(done_o), 64'(0));
        chk("reset_dz", 64'(div_zero_o), 64'(0));
        rst_ni = 1'b1;
        @(negedge clk);

        mt(1'b1, 1'b1, 32'hCAFE_F00D, "mt_both");
        mt(1'b1, 1'b0, 32'h1111_2222, "mthi");
        mt(1'b0, 1'b1, 32'h3333_4444, "mtlo");

        // Abort a MULT with reset after E10
        issue(2'b01, 32'hFFFF_FFF3, 32'h0000_0101, 1'b0, "mult_abort");
        repeat (10) @(posedge clk);
        #2;
        rst_ni = 1'b0;
        exp_q.delete();
        hi_m = '0;
        lo_m = '0;
        #1;
        chk("abort_hi", 64'(hi_o), 64'(0));
        chk("abort_lo", 64'(lo_o), 64'(0));
        chk("abort_busy", 64'(busy_o), 64'(0));
        chk("abort_done", 64'(done_o), 64'(0));
        chk("abort_dz", 64'(div_zero_o), 64'(0));
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);

        run(2'b00, 32'd3, 32'd5, "multu_3x5");
        run(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        run(2'b01, -32'sd3, 32'd7, "mult_m3x7");
        run(2'b11, -32'sd7, 32'd2, "div_m7d2");
        run(2'b10, 32'd100, 32'd0, "divu_by_zero");
        run(2'b10, 32'd100, 32'd7, "divu_100d7");
        run(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");

        // Start and Mthi while busy must be ignored
        hi_prev = hi_m;
        issue(2'b00, 32'd12345, 32'd6789, 1'b0, "multu_busy_restart");
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b11; b_i = 32'h0; mthi_i = 1'b1; a_i = 32'h1234_5678;
        @(negedge clk);
        start_i = 1'b0; mthi_i = 1'b0;
        chk("busy_mthi_hi", 64'(hi_o), 64'(hi_prev));
        chk("busy_start_dz", 64'(div_zero_o), 64'(0));
        wait_done(31, "multu_busy_restart");

        // Mtlo in the same cycle as Start: Start wins
        lo_prev = lo_m;
        issue(2'b00, 32'd7, 32'd9, 1'b1, "multu_with_mtlo");
        chk("mtlo_start_lo", 64'(lo_o), 64'(lo_prev));
        wait_done(33, "multu_with_mtlo");

        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: ra = 32'($urandom_range(0, 255));
                default: ;
            endcase
            if ($urandom_range(0, 5) == 0)
                mt(1'($urandom_range(0, 1)), 1'b1, $urandom, $sformatf("rand_mt%0d", i));
            run(rop, ra, rb, $sformatf("rand%0d_op%0d", i, rop));
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
